// File: rtl/tcp_pkg.sv
// Shared definitions for the TCP transmit and receive datapaths.
//   tx_state_e  : transmit framer state encoding
//   HDR_BYTES   : header bytes that follow the preamble
//   FLAG_*      : TCP flag bit positions inside the 9-bit flags field
//   SEQ_W/ACK_W/FLAGS_W/WIN_W : field widths
//   csum_add()  : 16-bit ones-complement add with end-around carry
package tcp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY_ADDR,
        S_PAY_WAIT,
        S_PAY_SEND,
        S_CSUM,
        S_DONE
    } tx_state_e;

    localparam int HDR_BYTES = 14;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_ACK = 4;

    localparam int SEQ_W   = 32;
    localparam int ACK_W   = 32;
    localparam int FLAGS_W = 9;
    localparam int WIN_W   = 16;

    // The folded carry can never carry again: the largest raw sum is
    // 0x1FFFE, which folds to 0xFFFF.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'b0, s[16]};
    endfunction

endpackage

// File: rtl/tcp_packet_tx_if.sv
// Handshake/bus bundle between the transmit framer and its neighbours.
//   master : the framer (drives tx stream, payload address, status)
//   slave  : surroundings (main FSM, payload memory, line modulator)
// Signals: start/control/seq_in/ack_in/flags_in/window_in from the main FSM,
// data_addr/data_rdata to the payload memory, tx_data/tx_valid/tx_ready
// byte stream, busy and packet_sent status.
interface tcp_packet_tx_if
    import tcp_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic                 start;
    logic                 control;
    logic [SEQ_W-1:0]     seq_in;
    logic [ACK_W-1:0]     ack_in;
    logic [FLAGS_W-1:0]   flags_in;
    logic [WIN_W-1:0]     window_in;
    logic [ADDR_W-1:0]    data_addr;
    logic [7:0]           data_rdata;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic                 packet_sent;

    modport master (
        input  start, control, seq_in, ack_in, flags_in, window_in,
        input  data_rdata, tx_ready,
        output data_addr, tx_data, tx_valid, busy, packet_sent
    );

    modport slave (
        output start, control, seq_in, ack_in, flags_in, window_in,
        output data_rdata, tx_ready,
        input  data_addr, tx_data, tx_valid, busy, packet_sent
    );

endinterface

// File: rtl/tcp_csum16.sv
// 16-bit ones-complement checksum over a byte stream.
// Bytes pair big-endian (first byte of a pair is the high byte); a trailing
// odd byte is padded with a zero low byte.
// Ports:
//   clk, reset  : clock, async active-high reset
//   clear       : restart the sum (takes priority over valid)
//   valid       : data_byte is part of the summed stream this cycle
//   data_byte   : next stream byte
//   csum        : ~sum including the byte presented this cycle, so the
//                 result is usable in the same cycle as the last byte
module tcp_csum16
    import tcp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        valid,
    input  logic [7:0]  data_byte,
    output logic [15:0] csum
);

    logic [15:0] sum_q, sum_n;
    logic [7:0]  hi_q, hi_n;
    logic        odd_q, odd_n;
    logic [15:0] sum_final;

    always_comb begin
        sum_n = sum_q;
        hi_n  = hi_q;
        odd_n = odd_q;
        if (clear) begin
            sum_n = 16'h0000;
            hi_n  = 8'h00;
            odd_n = 1'b0;
        end else if (valid) begin
            if (odd_q) begin
                sum_n = csum_add(sum_q, {hi_q, data_byte});
                odd_n = 1'b0;
            end else begin
                hi_n  = data_byte;
                odd_n = 1'b1;
            end
        end
        // A half-filled word counts with a zero low byte.
        sum_final = odd_n ? csum_add(sum_n, {hi_n, 8'h00}) : sum_n;
        csum      = ~sum_final;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 16'h0000;
            hi_q  <= 8'h00;
            odd_q <= 1'b0;
        end else begin
            sum_q <= sum_n;
            hi_q  <= hi_n;
            odd_q <= odd_n;
        end
    end

endmodule

// File: rtl/tcp_packet_tx.sv
// TCP transmit framer: captures SEQ/ACK/flags/window on the main FSM's
// outgoing-ready level and serialises a framed packet onto a byte stream.
// Frame: A5 preamble, SEQ[4], ACK[4], {7'b0,flags[8]}, flags[7:0],
// window[2], len, 8'h00, payload[len], optional checksum[2].
// Ports:
//   clk, reset : clock, async active-high reset
//   bus        : tcp_packet_tx_if.master (start/fields in, payload memory
//                read port, tx byte stream, busy, packet_sent)
// Build option: TCP_TX_CSUM_EN appends a 16-bit ones-complement checksum
// over every byte after the preamble; without it the frame ends after the
// last header/payload byte.
//
// state      | meaning
// S_IDLE     | waiting for start while armed
// S_HDR      | preamble + 14 header bytes, one per handshake
// S_PAY_ADDR | payload address presented to memory
// S_PAY_WAIT | memory read latency; byte loaded into tx_data
// S_PAY_SEND | payload byte on the stream until accepted
// S_CSUM     | checksum high then low byte
// S_DONE     | packet_sent pulse, then back to idle
module tcp_packet_tx
    import tcp_pkg::*;
#(
    parameter int          PAYLOAD_BYTES = 16,
    parameter int          ADDR_W        = 4,
    parameter logic [7:0]  PREAMBLE      = 8'hA5
)
(
    input  logic            clk,
    input  logic            reset,
    tcp_packet_tx_if.master bus
);

    localparam logic [7:0]        LEN_BYTE  = 8'(PAYLOAD_BYTES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAYLOAD_BYTES - 1);
    localparam logic [3:0]        LAST_HDR  = 4'(HDR_BYTES);

    tx_state_e            state_q, state_n;
    logic [3:0]           hdr_idx_q, hdr_idx_n;
    logic                 armed_q, armed_n;
    logic [SEQ_W-1:0]     seq_q, seq_n;
    logic [ACK_W-1:0]     ack_q, ack_n;
    logic [FLAGS_W-1:0]   flags_q, flags_n;
    logic [WIN_W-1:0]     win_q, win_n;
    logic                 ctrl_q, ctrl_n;
    logic [7:0]           tx_data_q, tx_data_n;
    logic                 tx_valid_q, tx_valid_n;
    logic [ADDR_W-1:0]    data_addr_q, data_addr_n;
    logic                 busy_q, busy_n;
    logic                 sent_q, sent_n;
    logic [7:0]           hdr_next_byte;
    logic                 accept;
    logic                 hs;
    logic                 tail;

    assign accept = (state_q == S_IDLE) && bus.start && armed_q;
    assign hs     = tx_valid_q && bus.tx_ready;

`ifdef TCP_TX_CSUM_EN
    logic        csum_valid;
    logic [15:0] csum_val;
    logic        csum_idx_q, csum_idx_n;

    // Preamble is excluded from the sum.
    assign csum_valid = hs && (((state_q == S_HDR) && (hdr_idx_q != 4'd0)) ||
                               (state_q == S_PAY_SEND));

    tcp_csum16 u_csum (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .valid     (csum_valid),
        .data_byte (tx_data_q),
        .csum      (csum_val)
    );
`endif

    // Header byte that follows the one currently on the stream.
    always_comb begin
        hdr_next_byte = 8'h00;
        case (hdr_idx_q + 4'd1)
            4'd1:    hdr_next_byte = seq_q[31:24];
            4'd2:    hdr_next_byte = seq_q[23:16];
            4'd3:    hdr_next_byte = seq_q[15:8];
            4'd4:    hdr_next_byte = seq_q[7:0];
            4'd5:    hdr_next_byte = ack_q[31:24];
            4'd6:    hdr_next_byte = ack_q[23:16];
            4'd7:    hdr_next_byte = ack_q[15:8];
            4'd8:    hdr_next_byte = ack_q[7:0];
            4'd9:    hdr_next_byte = {7'b0, flags_q[8]};
            4'd10:   hdr_next_byte = flags_q[7:0];
            4'd11:   hdr_next_byte = win_q[15:8];
            4'd12:   hdr_next_byte = win_q[7:0];
            4'd13:   hdr_next_byte = ctrl_q ? 8'h00 : LEN_BYTE;
            default: hdr_next_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_n     = state_q;
        hdr_idx_n   = hdr_idx_q;
        armed_n     = armed_q;
        seq_n       = seq_q;
        ack_n       = ack_q;
        flags_n     = flags_q;
        win_n       = win_q;
        ctrl_n      = ctrl_q;
        tx_data_n   = tx_data_q;
        tx_valid_n  = tx_valid_q;
        data_addr_n = data_addr_q;
        busy_n      = busy_q;
        sent_n      = 1'b0;
        tail        = 1'b0;
`ifdef TCP_TX_CSUM_EN
        csum_idx_n  = csum_idx_q;
`endif

        // Holding start high sends one frame; a low cycle re-arms.
        if (!bus.start) begin
            armed_n = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    armed_n    = 1'b0;
                    seq_n      = bus.seq_in;
                    ack_n      = bus.ack_in;
                    flags_n    = bus.flags_in;
                    win_n      = bus.window_in;
                    ctrl_n     = bus.control;
                    hdr_idx_n  = 4'd0;
                    tx_data_n  = PREAMBLE;
                    tx_valid_n = 1'b1;
                    busy_n     = 1'b1;
                    state_n    = S_HDR;
                end
            end
            S_HDR: begin
                if (hs) begin
                    if (hdr_idx_q == LAST_HDR) begin
                        if (ctrl_q) begin
                            tail = 1'b1;
                        end else begin
                            data_addr_n = '0;
                            tx_valid_n  = 1'b0;
                            state_n     = S_PAY_ADDR;
                        end
                    end else begin
                        hdr_idx_n = hdr_idx_q + 4'd1;
                        tx_data_n = hdr_next_byte;
                    end
                end
            end
            S_PAY_ADDR: begin
                state_n = S_PAY_WAIT;
            end
            S_PAY_WAIT: begin
                tx_data_n  = bus.data_rdata;
                tx_valid_n = 1'b1;
                state_n    = S_PAY_SEND;
            end
            S_PAY_SEND: begin
                if (hs) begin
                    if (data_addr_q == LAST_ADDR) begin
                        tail = 1'b1;
                    end else begin
                        data_addr_n = data_addr_q + 1'b1;
                        tx_valid_n  = 1'b0;
                        state_n     = S_PAY_ADDR;
                    end
                end
            end
`ifdef TCP_TX_CSUM_EN
            S_CSUM: begin
                if (hs) begin
                    if (!csum_idx_q) begin
                        tx_data_n  = csum_val[7:0];
                        csum_idx_n = 1'b1;
                    end else begin
                        tx_valid_n = 1'b0;
                        sent_n     = 1'b1;
                        state_n    = S_DONE;
                    end
                end
            end
`endif
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                tx_valid_n = 1'b0;
                busy_n     = 1'b0;
                state_n    = S_IDLE;
            end
        endcase

        // Last header/payload byte accepted: checksum trailer or finish.
        if (tail) begin
`ifdef TCP_TX_CSUM_EN
            // csum_val already includes the byte being accepted this cycle.
            tx_data_n  = csum_val[15:8];
            tx_valid_n = 1'b1;
            csum_idx_n = 1'b0;
            state_n    = S_CSUM;
`else
            tx_valid_n = 1'b0;
            sent_n     = 1'b1;
            state_n    = S_DONE;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hdr_idx_q   <= 4'd0;
            armed_q     <= 1'b1;
            seq_q       <= '0;
            ack_q       <= '0;
            flags_q     <= '0;
            win_q       <= '0;
            ctrl_q      <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            data_addr_q <= '0;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
`ifdef TCP_TX_CSUM_EN
            csum_idx_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            hdr_idx_q   <= hdr_idx_n;
            armed_q     <= armed_n;
            seq_q       <= seq_n;
            ack_q       <= ack_n;
            flags_q     <= flags_n;
            win_q       <= win_n;
            ctrl_q      <= ctrl_n;
            tx_data_q   <= tx_data_n;
            tx_valid_q  <= tx_valid_n;
            data_addr_q <= data_addr_n;
            busy_q      <= busy_n;
            sent_q      <= sent_n;
`ifdef TCP_TX_CSUM_EN
            csum_idx_q  <= csum_idx_n;
`endif
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.data_addr   = data_addr_q;
    assign bus.busy        = busy_q;
    assign bus.packet_sent = sent_q;

endmodule
